// File: rtl/ife_core_scheduler.sv
// ife_core_scheduler: picks two idle cores round-robin, starts them, waits for both done
// pulses, then commits the block or falls back to serial re-execution on timeout.
module ife_core_scheduler #(
    parameter int BLOCK_ID_WIDTH = 8,
    parameter int NUM_CORES = 4,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int CORE_IDX_WIDTH = $clog2(NUM_CORES)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    input  logic [BLOCK_ID_WIDTH-1:0] req_block_id,
    output logic                      req_ready,
    input  logic [NUM_CORES-1:0]      core_idle_mask,
    output logic [NUM_CORES-1:0]      core_start,
    output logic [CORE_IDX_WIDTH-1:0] core_sel_0,
    output logic [CORE_IDX_WIDTH-1:0] core_sel_1,
    input  logic [NUM_CORES-1:0]      core_done,
    output logic                      commit_valid,
    output logic [BLOCK_ID_WIDTH-1:0] active_block_id,
    output logic                      timeout_fallback,
    output logic                      busy
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    if (NUM_CORES < 2) begin : g_bad_cores
        $error("NUM_CORES must be >= 2");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be >= 2");
    end

    typedef enum logic [1:0] {IDLE, RUN, COMMIT, ABORT} state_t;

    state_t                    state, state_n;
    logic [CORE_IDX_WIDTH-1:0] rr_ptr, cand0, cand1, rr_next;
    logic [TW-1:0]             timer;
    logic [1:0]                done_seen;
    logic [NUM_CORES-1:0]      start_q;
    logic                      found0, found1, accept, d0, d1;

    // Scan from rr_ptr with wrap; cand1 is taken before cand0 is claimed so one index never fills both.
    always_comb begin
        cand0 = '0;
        cand1 = '0;
        found0 = 1'b0;
        found1 = 1'b0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (core_idle_mask[(int'(rr_ptr) + k) % NUM_CORES] && found0 && !found1) begin
                cand1 = CORE_IDX_WIDTH'((int'(rr_ptr) + k) % NUM_CORES);
                found1 = 1'b1;
            end
            if (core_idle_mask[(int'(rr_ptr) + k) % NUM_CORES] && !found0) begin
                cand0 = CORE_IDX_WIDTH'((int'(rr_ptr) + k) % NUM_CORES);
                found0 = 1'b1;
            end
        end
    end

    assign rr_next          = (cand1 == CORE_IDX_WIDTH'(NUM_CORES - 1)) ? '0 : cand1 + 1'b1;
    assign req_ready        = !rst && state == IDLE && found1;
    assign accept           = req_valid && req_ready;
    assign d0               = done_seen[0] | core_done[core_sel_0];
    assign d1               = done_seen[1] | core_done[core_sel_1];
    assign busy             = state != IDLE;
    assign commit_valid     = !rst && state == COMMIT;
    assign timeout_fallback = !rst && state == ABORT;
    assign core_start       = rst ? '0 : start_q;

    always_comb begin
        state_n = IDLE;
        state_n = state == IDLE ? (accept ? RUN : IDLE) :
                  state == RUN  ? ((d0 && d1) ? COMMIT : (timer == TW'(TIMEOUT_CYCLES - 1)) ? ABORT : RUN) :
                  IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr          <= '0;
            timer           <= '0;
            done_seen       <= '0;
            core_sel_0      <= '0;
            core_sel_1      <= '0;
            active_block_id <= '0;
            start_q         <= '0;
        end else begin
            start_q <= '0;
            if (accept) begin
                active_block_id <= req_block_id;
                core_sel_0      <= cand0;
                core_sel_1      <= cand1;
                rr_ptr          <= rr_next;
                timer           <= '0;
                done_seen       <= '0;
                start_q         <= (NUM_CORES'(1) << cand0) | (NUM_CORES'(1) << cand1);
            end else if (state == RUN) begin
                timer     <= timer + 1'b1;
                done_seen <= {d1, d0};
            end
        end
    end
endmodule

// File: tb/tb_ife_core_scheduler.sv
// tb_ife_core_scheduler: directed sequence with a scoreboard of expected commit/fallback strobes.
module tb_ife_core_scheduler;
    logic       clk = 1'b0;
    logic       rst, req_valid, req_ready, commit_valid, timeout_fallback, busy;
    logic [7:0] req_block_id, active_block_id;
    logic [3:0] core_idle_mask, core_start, core_done;
    logic [1:0] core_sel_0, core_sel_1;
    int         tests = 0;
    int         fails = 0;
    int         nstb;
    logic [9:0] sb[$];

    always #5 clk = ~clk;

    ife_core_scheduler #(.BLOCK_ID_WIDTH(8), .NUM_CORES(4), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_block_id(req_block_id),
        .req_ready(req_ready), .core_idle_mask(core_idle_mask), .core_start(core_start),
        .core_sel_0(core_sel_0), .core_sel_1(core_sel_1), .core_done(core_done),
        .commit_valid(commit_valid), .active_block_id(active_block_id),
        .timeout_fallback(timeout_fallback), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Outcome bits are {fallback, commit}, followed by the block ID.
    task automatic expect_out(input logic fb, input logic [7:0] id);
        sb.push_back({fb, !fb, id});
    endtask

    task automatic step;
        logic [9:0] e;
        @(posedge clk);
        #1;
        if (commit_valid || timeout_fallback) begin
            chk("sb_pending", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_result", {timeout_fallback, commit_valid, active_block_id}, e);
            end
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_block_id = 8'h00; core_idle_mask = 4'hF; core_done = 4'h0;
        step; step;
        chk("rst_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_start", core_start, 0);
        rst = 1'b0; #1;
        chk("idle_ready", req_ready, 1);
        chk("idle_sel0", core_sel_0, 0);
        chk("idle_sel1", core_sel_1, 0);
        chk("idle_id", active_block_id, 0);

        // basic commit, cores 0/1
        req_valid = 1'b1; req_block_id = 8'h12; expect_out(0, 8'h12);
        step; req_valid = 1'b0;
        chk("t1_start", core_start, 4'b0011);
        chk("t1_sel0", core_sel_0, 0);
        chk("t1_sel1", core_sel_1, 1);
        chk("t1_busy", busy, 1);
        chk("t1_ready", req_ready, 0);
        step;
        chk("t1_start_once", core_start, 0);
        step;
        core_done = 4'b0001; step; core_done = 4'b0000;
        step;
        chk("t1_wait", commit_valid, 0);
        core_done = 4'b0010; step; core_done = 4'b0000;
        chk("t1_commit", commit_valid, 1);
        chk("t1_id", active_block_id, 8'h12);
        step;
        chk("t1_commit_once", commit_valid, 0);
        chk("t1_idle", busy, 0);

        // wrap-around from rr_ptr=2, simultaneous done in start cycle
        core_idle_mask = 4'b1011; req_valid = 1'b1; req_block_id = 8'h34; #1;
        chk("t2_ready", req_ready, 1);
        expect_out(0, 8'h34);
        step; req_valid = 1'b0;
        chk("t2_start", core_start, 4'b1001);
        chk("t2_sel0", core_sel_0, 3);
        chk("t2_sel1", core_sel_1, 0);
        core_done = 4'b1001; step; core_done = 4'b0000;
        chk("t2_commit", commit_valid, 1);
        step;
        chk("t2_idle", busy, 0);

        // insufficient cores, then cores 1/2 from rr_ptr=1
        core_idle_mask = 4'b0100; req_valid = 1'b1; req_block_id = 8'h56; #1;
        chk("t3_not_ready", req_ready, 0);
        step;
        chk("t3_no_busy", busy, 0);
        chk("t3_no_start", core_start, 0);
        core_idle_mask = 4'b0110; #1;
        chk("t3_ready", req_ready, 1);
        expect_out(0, 8'h56);
        step; req_valid = 1'b0; core_idle_mask = 4'b0000;
        chk("t3_start", core_start, 4'b0110);
        chk("t3_sel0", core_sel_0, 1);
        chk("t3_sel1", core_sel_1, 2);
        core_done = 4'b1001; step; core_done = 4'b0000;
        chk("t3_foreign_done", commit_valid, 0);
        chk("t3_still_run", busy, 1);
        core_done = 4'b0010; step; core_done = 4'b0000;
        chk("t3_half_done", commit_valid, 0);
        core_done = 4'b0100; step; core_done = 4'b0000;
        chk("t3_commit", commit_valid, 1);
        step;
        core_idle_mask = 4'hF;

        // timeout: only core_sel_0 finishes
        req_valid = 1'b1; req_block_id = 8'h7F; expect_out(1, 8'h7F);
        step; req_valid = 1'b0;
        chk("t4_sel0", core_sel_0, 3);
        chk("t4_sel1", core_sel_1, 0);
        core_done = 4'b1000;
        nstb = 0;
        for (int i = 0; i < 63; i++) begin
            step; core_done = 4'b0000;
            nstb += int'(commit_valid | timeout_fallback);
        end
        chk("t4_quiet", nstb, 0);
        step;
        chk("t4_fallback", timeout_fallback, 1);
        chk("t4_no_commit", commit_valid, 0);
        chk("t4_id", active_block_id, 8'h7F);
        step;
        chk("t4_fallback_once", timeout_fallback, 0);
        chk("t4_idle", busy, 0);

        // second done on the final RUN cycle wins over timeout
        req_valid = 1'b1; req_block_id = 8'h80; expect_out(0, 8'h80);
        step; req_valid = 1'b0;
        chk("t4b_sel0", core_sel_0, 1);
        chk("t4b_sel1", core_sel_1, 2);
        core_done = 4'b0010;
        for (int i = 0; i < 63; i++) begin
            step; core_done = 4'b0000;
        end
        core_done = 4'b0100; step; core_done = 4'b0000;
        chk("t4b_commit", commit_valid, 1);
        chk("t4b_no_fallback", timeout_fallback, 0);
        step;

        // back-to-back accepts three cycles apart
        req_valid = 1'b1; req_block_id = 8'hA1; expect_out(0, 8'hA1);
        step; req_block_id = 8'hA2;
        chk("t5_sel0", core_sel_0, 3);
        core_done = 4'b1001; step; core_done = 4'b0000;
        chk("t5_commit", commit_valid, 1);
        chk("t5_commit_ready", req_ready, 0);
        step;
        chk("t5_ready", req_ready, 1);
        expect_out(0, 8'hA2);
        step; req_valid = 1'b0;
        chk("t5_start", core_start, 4'b0110);
        chk("t5_id", active_block_id, 8'hA2);
        core_done = 4'b0110; step; core_done = 4'b0000;
        chk("t5_commit2", commit_valid, 1);
        step;

        // reset in RUN drops the block and rewinds rr_ptr
        req_valid = 1'b1; req_block_id = 8'hB0;
        step; req_valid = 1'b0;
        chk("t6_start", core_start, 4'b1001);
        rst = 1'b1; core_done = 4'b1001;
        step; rst = 1'b0; core_done = 4'b0000; #1;
        chk("t6_busy", busy, 0);
        chk("t6_ready", req_ready, 1);
        chk("t6_commit", commit_valid, 0);
        chk("t6_fallback", timeout_fallback, 0);
        chk("t6_id", active_block_id, 0);
        step;
        chk("t6_quiet", busy, 0);
        req_valid = 1'b1; req_block_id = 8'hC3; expect_out(0, 8'hC3);
        step; req_valid = 1'b0;
        chk("t6_sel0", core_sel_0, 0);
        chk("t6_sel1", core_sel_1, 1);
        chk("t6_start2", core_start, 4'b0011);
        core_done = 4'b0011; step; core_done = 4'b0000;
        chk("t6_commit2", commit_valid, 1);
        step;

        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ife_core_scheduler.md
Name: ife_core_scheduler

Overview:
Sequences the redundant parallel execution path of the Instruction Flow Expander. The block accepts one safe block from the dispatch stage and picks two idle cores round-robin. It pulses their start lines, then waits for both done pulses. On completion it issues the commit-valid strobe with the block ID to the commit unit. If the cores do not finish in time, it raises a timeout fallback so the bypass path re-executes the block serially.

Parameters:
BLOCK_ID_WIDTH, 8, width of block identifier
NUM_CORES, 4, number of schedulable cores; must be >= 2 (elaboration-time assertion)
TIMEOUT_CYCLES, 64, maximum RUN cycles before abort; must be >= 2
CORE_IDX_WIDTH, $clog2(NUM_CORES), derived local parameter, not overridable

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
req_valid  input  1  dispatch offers a parallel-safe block
req_block_id  input  BLOCK_ID_WIDTH  ID of offered block
req_ready  output  1  scheduler can accept a block this cycle
core_idle_mask  input  NUM_CORES  1 = core idle (from monitor)
core_start  output  NUM_CORES  one-cycle start pulse, exactly two bits set when active
core_sel_0  output  CORE_IDX_WIDTH  index of first allocated core
core_sel_1  output  CORE_IDX_WIDTH  index of second allocated core
core_done  input  NUM_CORES  per-core completion pulse
commit_valid  output  1  one-cycle strobe to commit unit
active_block_id  output  BLOCK_ID_WIDTH  ID of block in flight; valid with commit_valid/timeout_fallback
timeout_fallback  output  1  one-cycle strobe: block must re-execute serially
busy  output  1  high whenever state != IDLE

Behaviour:
- Clock and reset: single clock domain on clk. rst is synchronous and active-high.
- Reset values: state=IDLE; rr_ptr=0; timer=0; done_seen=2'b00; core_sel_0=0; core_sel_1=0; active_block_id=0. All strobes and req_ready are 0 during rst.
- Eligibility (combinational): a core is eligible when its core_idle_mask bit is 1.
  - cand0 = first eligible index scanning rr_ptr, rr_ptr+1, ... modulo NUM_CORES.
  - cand1 = next eligible index after cand0 in the same scan.
- req_ready = (state==IDLE) && (at least two eligible cores). It must not depend on req_valid.
- Accept condition: req_valid && req_ready. On the accepting edge:
  - latch active_block_id, core_sel_0=cand0, core_sel_1=cand1;
  - rr_ptr = (cand1+1) mod NUM_CORES;
  - timer=0; done_seen=0; state -> RUN.
- States:
  - IDLE: waits for accept.
  - RUN:
    - core_start is registered and driven high for the first RUN cycle only, on bits core_sel_0 and core_sel_1.
    - done_seen[0] sets on core_done[core_sel_0]; done_seen[1] sets on core_done[core_sel_1]. Both may set in the same cycle.
    - core_done bits of unallocated cores are ignored.
    - Done pulses count from the first RUN cycle, including the start cycle.
    - timer increments every RUN cycle.
    - If both done bits are set or being set this cycle -> COMMIT.
    - Else if timer == TIMEOUT_CYCLES-1 -> ABORT.
    - Done takes priority over timeout in the same cycle.
  - COMMIT: commit_valid=1 for exactly one cycle with active_block_id held, then -> IDLE.
  - ABORT: timeout_fallback=1 for exactly one cycle with active_block_id held, then -> IDLE.
- Throughput:
  - One block in flight.
  - Minimum accept-to-accept spacing is 3 cycles: accept at c0, RUN c1 with both done at c1, COMMIT c2, IDLE/accept c3.
  - req_ready is 0 in COMMIT and ABORT.
- Ignored inputs:
  - Late core_done pulses arriving in COMMIT, ABORT or IDLE are ignored; there is no error.
  - core_idle_mask changes after acceptance do not affect the allocated pair.
- Wrap-around: the round-robin scan wraps modulo NUM_CORES. cand1 may be numerically lower than cand0.
- Reset mid-operation (RUN, COMMIT or ABORT): all state returns to reset values on the next edge. No commit_valid or timeout_fallback is emitted for the aborted block.

Test Plan:
1. Basic commit: rst, then idle_mask=4'b1111, req_valid with id=0x12.
   - Required: accept at c0; core_start=4'b0011 at c1; core_sel_0=0, core_sel_1=1.
   - Drive core_done[0] at c3 and core_done[1] at c5 -> commit_valid at c6 with active_block_id=0x12; rr_ptr=2.
2. Round-robin wrap: rr_ptr=2, idle_mask=4'b1011, new request.
   - Required: cand0=3, cand1=0; core_start=4'b1001; rr_ptr becomes 1.
3. Insufficient cores: idle_mask=4'b0100 with req_valid held.
   - Required: req_ready=0 and no start.
   - Set mask to 4'b0110 -> accept next cycle; cores 1 and 2 start.
4. Timeout: accept id=0x7F, TIMEOUT_CYCLES=64, only core_sel_0 reports done.
   - Required: timeout_fallback pulses once exactly 64 cycles after the first RUN cycle, with id 0x7F; commit_valid stays 0.
   - Repeat with the second done on the final RUN cycle -> commit_valid, no fallback.
5. Edge cases:
   - Simultaneous done on both cores in the start cycle -> COMMIT next cycle.
   - Accept a new request 3 cycles after the previous accept.
   - core_done from an unallocated core during RUN does not complete the block.
6. Reset mid-RUN: assert rst one cycle in RUN.
   - Required: busy=0, req_ready recomputed, rr_ptr=0, no strobes; the next request allocates cores 0 and 1.
